// File: rtl/fcta_stage_seq_pkg.sv
// definesPkg: shared types for the FC training accelerator.
// Stage commands, sequencer FSM states, default layer count.
package definesPkg;

  localparam int STAGE_BW       = 3;
  localparam int NUM_LAYERS_DEF = 3;
  localparam int WDT_W          = 16;

  typedef enum logic [STAGE_BW-1:0] {
    STAGE_IDLE    = 3'd0,
    STAGE_A0      = 3'd1,
    STAGE_FP      = 3'd2,
    STAGE_SOFTMAX = 3'd3,
    STAGE_BPDZ    = 3'd4,
    STAGE_BPDW    = 3'd5,
    STAGE_BPDA    = 3'd6,
    STAGE_PU      = 3'd7
  } stage_t;

  typedef enum logic [1:0] {
    SQ_IDLE  = 2'd0,
    SQ_ISSUE = 2'd1,
    SQ_WAIT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/fcta_stage_seq_next.sv
// fcta_stage_next: combinational successor of a (stage, layer) command.
// In: i_stage, i_layer. Out: o_next_stage, o_next_layer, o_last (final PU).
module fcta_stage_next
  import definesPkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int LAYER_BW   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic [STAGE_BW-1:0] i_stage,
  input  logic [LAYER_BW-1:0] i_layer,
  output logic [STAGE_BW-1:0] o_next_stage,
  output logic [LAYER_BW-1:0] o_next_layer,
  output logic                o_last
);

  localparam logic [LAYER_BW-1:0] LAST =
    LAYER_BW'(NUM_LAYERS - 1);

  logic w_top;
  logic w_bot;
  stage_t w_stage;
  stage_t w_nstage;

  assign w_top   = (i_layer == LAST);
  assign w_bot   = (i_layer == '0);
  assign w_stage = stage_t'(i_stage);

  always_comb begin
    w_nstage     = STAGE_IDLE;
    o_next_layer = '0;
    o_last       = 1'b0;
    case (w_stage)
      STAGE_A0: begin
        w_nstage = STAGE_FP;
      end
      STAGE_FP: begin
        if (w_top) begin
          w_nstage     = STAGE_SOFTMAX;
          o_next_layer = LAST;
        end else begin
          w_nstage     = STAGE_FP;
          o_next_layer = i_layer + LAYER_BW'(1);
        end
      end
      STAGE_SOFTMAX: begin
        w_nstage     = STAGE_BPDZ;
        o_next_layer = LAST;
      end
      STAGE_BPDZ: begin
        w_nstage     = STAGE_BPDW;
        o_next_layer = i_layer;
      end
      STAGE_BPDW: begin
        // layer 0 has no upstream activation to backprop into
        if (w_bot) begin
          w_nstage = STAGE_PU;
        end else begin
          w_nstage     = STAGE_BPDA;
          o_next_layer = i_layer;
        end
      end
      STAGE_BPDA: begin
        w_nstage     = STAGE_BPDZ;
        o_next_layer = i_layer - LAYER_BW'(1);
      end
      STAGE_PU: begin
        if (w_top) begin
          o_last = 1'b1;
        end else begin
          w_nstage     = STAGE_PU;
          o_next_layer = i_layer + LAYER_BW'(1);
        end
      end
      default: begin
        w_nstage = STAGE_IDLE;
      end
    endcase
  end

  assign o_next_stage = w_nstage;

endmodule

// File: rtl/fcta_stage_seq.sv
// fcta_stage_seq: training-step sequencer, issues stage/layer commands.
// Ports: clk, rst, start_i, abort_i, stage_done_i -> stage_start_o,
// stage_o, layer_o, busy_o, done_o, error_o. Option: FCTA_STAGE_WDT_EN.
module fcta_stage_seq
  import definesPkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int LAYER_BW   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  parameter int WDT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  output logic                stage_start_o,
  output logic [STAGE_BW-1:0] stage_o,
  output logic [LAYER_BW-1:0] layer_o,
  input  logic                stage_done_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o
);

  seq_state_t          r_state;
  stage_t              r_stage;
  logic [LAYER_BW-1:0] r_layer;
  logic                r_start;
  logic                r_busy;
  logic                r_done;

  logic [STAGE_BW-1:0] w_nxt_stage;
  logic [LAYER_BW-1:0] w_nxt_layer;
  logic                w_last;
  logic                w_wdt_hit;

  fcta_stage_next #(
    .NUM_LAYERS (NUM_LAYERS),
    .LAYER_BW   (LAYER_BW)
  ) u_next (
    .i_stage      (r_stage),
    .i_layer      (r_layer),
    .o_next_stage (w_nxt_stage),
    .o_next_layer (w_nxt_layer),
    .o_last       (w_last)
  );

`ifdef FCTA_STAGE_WDT_EN
  localparam logic [WDT_W-1:0] WDT_LIM =
    WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] r_wdt;
  logic             r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdt <= '0;
    end else if (r_state == SQ_ISSUE) begin
      r_wdt <= '0;
    end else if (r_state == SQ_WAIT) begin
      r_wdt <= r_wdt + WDT_W'(1);
    end
  end

  assign w_wdt_hit = (r_wdt == WDT_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (!abort_i) begin
      if (r_state == SQ_IDLE && start_i) begin
        r_err <= 1'b0;
      end else if (r_state == SQ_WAIT &&
                   !stage_done_i && w_wdt_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign error_o = r_err;
`else
  assign w_wdt_hit = 1'b0;
  assign error_o   = 1'b0;
`endif

  // ISSUE spans a load cycle (r_start low) and a pulse cycle
  // (r_start high); entry from IDLE arrives already pulsing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SQ_IDLE;
      r_stage <= STAGE_IDLE;
      r_layer <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      if (abort_i) begin
        r_state <= SQ_IDLE;
        r_stage <= STAGE_IDLE;
        r_layer <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          SQ_IDLE: begin
            if (start_i) begin
              r_state <= SQ_ISSUE;
              r_stage <= STAGE_A0;
              r_layer <= '0;
              r_busy  <= 1'b1;
              r_start <= 1'b1;
            end
          end
          SQ_ISSUE: begin
            if (r_start) begin
              r_state <= SQ_WAIT;
            end else begin
              r_start <= 1'b1;
            end
          end
          SQ_WAIT: begin
            if (stage_done_i) begin
              if (w_last) begin
                r_state <= SQ_IDLE;
                r_stage <= STAGE_IDLE;
                r_layer <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= SQ_ISSUE;
                r_stage <= stage_t'(w_nxt_stage);
                r_layer <= w_nxt_layer;
              end
            end else if (w_wdt_hit) begin
              r_state <= SQ_IDLE;
              r_stage <= STAGE_IDLE;
              r_layer <= '0;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= SQ_IDLE;
            r_stage <= STAGE_IDLE;
            r_layer <= '0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign stage_start_o = r_start;
  assign stage_o       = r_stage;
  assign layer_o       = r_layer;
  assign busy_o        = r_busy;
  assign done_o        = r_done;

endmodule

// File: tb/tb_fcta_stage_seq.sv
// Bench for fcta_stage_seq: scoreboard of expected stage commands.
// Main DUT has 3 layers; a second 1-layer DUT covers the edge case.
module tb_fcta_stage_seq;
  import definesPkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_i, abort_i;
  logic       rsp_done, spur_done, stage_done;
  logic       stage_start_o, busy_o, done_o, error_o;
  logic [2:0] stage_o;
  logic [1:0] layer_o;

  logic       start1, done1;
  logic       start1_o, busy1_o, done1_o, error1_o;
  logic [2:0] stage1_o;
  logic [0:0] layer1_o;
  logic       abort1;

  assign stage_done = rsp_done | spur_done;

  fcta_stage_seq #(
    .NUM_LAYERS (3),
    .WDT_CYCLES (100)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .stage_start_o (stage_start_o),
    .stage_o       (stage_o),
    .layer_o       (layer_o),
    .stage_done_i  (stage_done),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  fcta_stage_seq #(
    .NUM_LAYERS (1),
    .WDT_CYCLES (100)
  ) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start1),
    .abort_i       (abort1),
    .stage_start_o (start1_o),
    .stage_o       (stage1_o),
    .layer_o       (layer1_o),
    .stage_done_i  (done1),
    .busy_o        (busy1_o),
    .done_o        (done1_o),
    .error_o       (error1_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic signed [31:0] got,
                     logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int q[$];
  int q1[$];
  int pcq[$];

  function automatic void add(bit w, stage_t s, int l);
    if (w) q1.push_back(int'(s) * 16 + l);
    else q.push_back(int'(s) * 16 + l);
  endfunction

  function automatic void push_seq(bit w, int nl);
    add(w, STAGE_A0, 0);
    for (int l = 0; l < nl; l++) add(w, STAGE_FP, l);
    add(w, STAGE_SOFTMAX, nl - 1);
    for (int l = nl - 1; l >= 0; l--) begin
      add(w, STAGE_BPDZ, l);
      add(w, STAGE_BPDW, l);
      if (l > 0) add(w, STAGE_BPDA, l);
    end
    for (int l = 0; l < nl; l++) add(w, STAGE_PU, l);
  endfunction

  int cyc = 0;
  int n_pulse = 0, n_done = 0, done_cyc = 0;
  int n_pulse1 = 0, n_done1 = 0;
  int last_sl = -1;
  int dly = 2;
  int rcnt = 0;
  int start_cyc = 0;
  bit pend = 0, pend1 = 0, hang_fp0 = 0;
  int sl, sl1;

  // responder + scoreboard, sampled 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    cyc++;
    rsp_done = 1'b0;
    if (pend) begin
      if (rcnt <= 1) begin
        rsp_done = 1'b1;
        pend = 0;
      end else begin
        rcnt--;
      end
    end
    if (stage_start_o) begin
      sl = int'(stage_o) * 16 + int'(layer_o);
      n_pulse++;
      last_sl = sl;
      pcq.push_back(cyc);
      if (q.size() == 0) chk("extra_start", sl, -1);
      else chk("seq", sl, q.pop_front());
      if (!(hang_fp0 && sl == int'(STAGE_FP) * 16)) begin
        pend = 1;
        rcnt = dly;
      end
    end
    if (done_o) begin
      n_done++;
      done_cyc = cyc;
      chk("q_left_at_done", q.size(), 0);
    end
    done1 = pend1;
    pend1 = start1_o;
    if (start1_o) begin
      sl1 = int'(stage1_o) * 16 + int'(layer1_o);
      n_pulse1++;
      if (q1.size() == 0) chk("l1_extra_start", sl1, -1);
      else chk("l1_seq", sl1, q1.pop_front());
    end
    if (done1_o) begin
      n_done1++;
      chk("l1_q_left", q1.size(), 0);
    end
  end

  task automatic chk_reset_vals(string tag);
    chk({tag, "_start"}, stage_start_o, 0);
    chk({tag, "_stage"}, stage_o, int'(STAGE_IDLE));
    chk({tag, "_layer"}, layer_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, error_o, 0);
  endtask

  task automatic run_step(string tag, bit noisy);
    int p0;
    int d0;
    p0 = n_pulse;
    d0 = n_done;
    push_seq(0, 3);
    pcq.delete();
    start_i = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0;
    chk({tag, "_busy_t1"}, busy_o, 1);
    chk({tag, "_pulse_t1"}, stage_start_o, 1);
    chk({tag, "_a0_t1"}, stage_o, int'(STAGE_A0));
    chk({tag, "_err_clr"}, error_o, 0);
    for (int i = 0; i < 400 && n_done == d0; i++) begin
      @(negedge clk);
      start_i = (noisy && (i % 7 == 3)) ? 1'b1 : 1'b0;
    end
    start_i = 1'b0;
    chk({tag, "_ndone"}, n_done - d0, 1);
    chk({tag, "_npulse"}, n_pulse - p0, 16);
    chk({tag, "_done_busy"}, busy_o, 0);
    chk({tag, "_done_stage"}, stage_o, int'(STAGE_IDLE));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done_o, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_sl(string tag, stage_t s, int l);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (last_sl == int'(s) * 16 + l) break;
    end
    chk({tag, "_reached"}, last_sl, int'(s) * 16 + l);
  endtask

  initial begin
    int d0;
    int k;
    rst = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    spur_done = 1'b0;
    rsp_done = 1'b0;
    start1 = 1'b0;
    done1 = 1'b0;
    abort1 = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    dly = 2;
    run_step("base", 0);

    dly = 1;
    run_step("zw", 0);
    chk("zw_latency", done_cyc - start_cyc, 48);
    chk("zw_first", pcq[0] - start_cyc, 1);
    for (int i = 1; i < pcq.size(); i++)
      chk("zw_spacing", pcq[i] - pcq[i - 1], 3);

    dly = 2;
    spur_done = 1'b1;
    repeat (2) @(negedge clk);
    spur_done = 1'b0;
    chk("spur_busy", busy_o, 0);
    chk("spur_nopulse", stage_start_o, 0);
    run_step("noisy", 1);

    push_seq(0, 3);
    last_sl = -1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_sl("abort", STAGE_BPDW, 1);
    @(negedge clk);
    abort_i = 1'b1;
    d0 = n_done;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_stage", stage_o, int'(STAGE_IDLE));
    q.delete();
    pend = 0;
    repeat (5) @(negedge clk);
    chk("abort_nodone", n_done - d0, 0);
    run_step("restart", 0);

    push_seq(0, 3);
    last_sl = -1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_sl("rst", STAGE_FP, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    q.delete();
    pend = 0;
    repeat (4) @(negedge clk);
    run_step("post_rst", 0);

`ifdef FCTA_STAGE_WDT_EN
    hang_fp0 = 1;
    push_seq(0, 3);
    last_sl = -1;
    d0 = n_done;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_sl("wdt", STAGE_FP, 0);
    for (k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (error_o) break;
    end
    chk("wdt_err", error_o, 1);
    chk("wdt_busy", busy_o, 0);
    chk("wdt_in_time", (k <= 101) ? 1 : 0, 1);
    chk("wdt_nodone", n_done - d0, 0);
    q.delete();
    hang_fp0 = 0;
    pend = 0;
    repeat (2) @(negedge clk);
    run_step("wdt_clr", 0);
`endif

    d0 = n_done1;
    k = n_pulse1;
    push_seq(1, 1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 100 && n_done1 == d0; i++)
      @(negedge clk);
    chk("l1_ndone", n_done1 - d0, 1);
    chk("l1_npulse", n_pulse1 - k, 6);
    chk("l1_busy", busy1_o, 0);
    chk("l1_err", error1_o, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fcta_stage_seq.md
# fcta_stage_seq

Training-step sequencer for the fully-connected training accelerator. On a start request it walks the datapath through one full training step, issuing each `stage_t` command together with a layer index: input load, forward pass, softmax, backprop dZ/dW/dA, and parameter update. It is the initiating end of the stage command interface; the datapath engines that decode `stage_o` are the responders and report completion with `stage_done_i`.

## Interface
Parameters:
- `NUM_LAYERS`, 3, number of FC layers (≥1)
- `LAYER_BW`, `$clog2(NUM_LAYERS)` (min 1), width of `layer_o`
- `WDT_CYCLES`, 65535, watchdog limit per stage (used only with `FCTA_STAGE_WDT_EN`)

Ports:
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `start_i` in 1: begin one training step; sampled only in IDLE
- `abort_i` in 1: abandon the current step; return to IDLE
- `stage_start_o` out 1: one-cycle pulse, command valid
- `stage_o` out `STAGE_BW`: current stage (`stage_t`)
- `layer_o` out `LAYER_BW`: layer index of the current stage
- `stage_done_i` in 1: responder completion pulse
- `busy_o` out 1: step in progress
- `done_o` out 1: one-cycle pulse, step complete
- `error_o` out 1: sticky watchdog error, cleared by `start_i` or `rst`

## Operation
- FSM states: `SQ_IDLE`, `SQ_ISSUE`, `SQ_WAIT`.
- Stage order for L = `NUM_LAYERS`:
  - A0 (layer 0)
  - FP for layers 0..L-1
  - SOFTMAX (layer L-1)
  - for l = L-1 down to 0: BPdZ(l), BPdW(l), then BPdA(l) only if l>0
  - PU for layers 0..L-1
- Total commands per step: 5L+1.
- IDLE: `start_i` loads A0/layer 0 and moves to ISSUE.
- ISSUE: pulses `stage_start_o`, then moves to WAIT.
- WAIT: on `stage_done_i`:
  - after the last PU(L-1): go to IDLE and pulse `done_o`
  - otherwise: load the next (stage, layer) and go to ISSUE
- `stage_o`/`layer_o` are stable from the `stage_start_o` cycle until the cycle after the accepted `stage_done_i`.
- `stage_o` reads `STAGE_IDLE` whenever the FSM is in IDLE.
- Ignored inputs:
  - `stage_done_i` outside WAIT, including in the ISSUE cycle
  - `start_i` while busy
- `abort_i` has priority over `stage_done_i` and `start_i` in any state:
  - next state IDLE, `stage_o`=IDLE
  - no `done_o` pulse
- L=1 edge case: sequence is A0, FP0, SOFTMAX, BPdZ0, BPdW0, PU0. No BPdA.

## Timing
- Reset values: `stage_start_o`=0, `stage_o`=`STAGE_IDLE`, `layer_o`=0, `busy_o`=0, `done_o`=0, `error_o`=0. FSM in IDLE.
- `start_i` high at cycle t: `busy_o`=1 and `stage_start_o` pulses with A0 at t+1.
- `stage_done_i` at cycle t in WAIT: next `stage_start_o` at t+2 (t+1 is the ISSUE load cycle).
- Final `stage_done_i` at t: `done_o`=1 and `busy_o`=0 at t+1.
- `rst` mid-step: all outputs return to their reset values on the next edge. An outstanding responder operation is dropped.
- All outputs are registered.

## Configuration
- `FCTA_STAGE_WDT_EN` defined:
  - a 16-bit per-stage counter clears on ISSUE and increments in WAIT
  - reaching `WDT_CYCLES` without `stage_done_i` sets `error_o` and returns the FSM to IDLE without `done_o`
- `FCTA_STAGE_WDT_EN` undefined:
  - no counter is built and `error_o` is tied 0
  - WAIT may last indefinitely

## Structure
- Shared package `definesPkg` gains:
  - `seq_state_t` (`SQ_IDLE`, `SQ_ISSUE`, `SQ_WAIT`)
  - `NUM_LAYERS_DEF`
  - reuses the existing `stage_t`/`STAGE_BW`
- Sub-module `fcta_stage_next`: purely combinational.
  - inputs: (stage, layer)
  - outputs: (next_stage, next_layer, last)
  - encodes the ordering rules above
  - keeps the FSM file small and lets the ordering be unit-tested alone.

## Test plan
- `NUM_LAYERS`=3, responder replies with done 2 cycles after each start:
  - exactly 16 `stage_start_o` pulses, in the order A0/0, FP0, FP1, FP2, SOFTMAX/2, BPdZ2, BPdW2, BPdA2, BPdZ1, BPdW1, BPdA1, BPdZ0, BPdW0, PU0, PU1, PU2
  - then a single `done_o`
- Zero-wait responder (done the cycle after start): starts are spaced 3 cycles apart, and `done_o` arrives at cycle 48 after `start_i`.
- Spurious `stage_done_i` while IDLE, and `start_i` pulses during the step: no effect. Sequence and count identical to the first scenario.
- `abort_i` asserted during BPdW1 WAIT:
  - next cycle `busy_o`=0, `stage_o`=IDLE, no `done_o`
  - a new `start_i` restarts at A0
- `rst` asserted during FP1: all outputs take their reset values on the next edge.
- With `FCTA_STAGE_WDT_EN`, `WDT_CYCLES`=100, responder never answers FP0:
  - `error_o`=1 and `busy_o`=0 within 101 cycles of the FP0 start
  - next `start_i` clears `error_o`
